imem_loader: RTL

Byte-stream program loader for the single-cycle CPU. It receives a framed program image over a valid/ready byte interface and writes it into the byte-addressed instruction memory, big-endian: the upper instruction byte goes to the even address. The CPU's reset is held asserted while loading and released only after the frame checksum verifies. The loader sits beside `top_cpu` and replaces bench-side direct memory preloading in hardware builds.

---
 rtl/imem_loader_pkg.sv | 6 +
 rtl/imem_loader.sv | 79 +++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and frame constants for the program loader
package imem_loader_pkg;
   typedef enum logic [2:0] {S_SYNC, S_LEN, S_DATA, S_CSUM, S_HOLD, S_RUN, S_ERR} state_t;
   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
   localparam int LEN_W = 9;
endpackage

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader into instruction memory, holds CPU in reset until checksum verifies
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready/in_data : byte stream input handshake
//   mem_we/mem_addr/mem_wdata : registered instruction-memory byte write port
//   cpu_reset, done, error    : CPU reset, load complete, last frame rejected
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int MEM_BYTES = 256,
   parameter int ADDR_W = 8,
   parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
   parameter int RST_HOLD = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_reset,
   output logic              done,
   output logic              error
);
   localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   state_t state, state_n;
   logic [LEN_W-1:0] cnt, len2;
   logic [ADDR_W-1:0] addr;
   logic [7:0] acc_x;
   logic [HW-1:0] hcnt;
   logic acc;
   assign in_ready = state != S_HOLD;
   assign cpu_reset = state != S_RUN;
   assign done = state == S_RUN;
   assign error = state == S_ERR;
   assign acc = in_valid && in_ready;
   assign len2 = {in_data, 1'b0};
   always_ff @(posedge clk)
      state <= reset ? S_SYNC : state_n;
   always_comb begin
      state_n = state;
      case (state)
         S_SYNC:       if (acc && in_data == SYNC_BYTE) state_n = S_LEN;
         S_LEN:        if (acc) state_n = (in_data == 8'd0 || len2 > LEN_W'(MEM_BYTES)) ? S_ERR : S_DATA;
         S_DATA:       if (acc && cnt == LEN_W'(1)) state_n = S_CSUM;
         S_CSUM:       if (acc) state_n = (in_data == acc_x) ? S_HOLD : S_ERR;
         S_HOLD:       if (hcnt == HW'(RST_HOLD - 1)) state_n = S_RUN;
         S_RUN, S_ERR: if (acc && in_data == SYNC_BYTE) state_n = S_LEN;
         default:      state_n = S_SYNC;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         addr <= '0;
         acc_x <= '0;
         hcnt <= '0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= acc && state == S_DATA;
         hcnt <= (state == S_HOLD) ? hcnt + 1'b1 : '0;
         if (acc && state == S_LEN) begin
            cnt <= len2;
            addr <= '0;
            acc_x <= '0;
         end
         if (acc && state == S_DATA) begin
            mem_addr <= addr;
            mem_wdata <= in_data;
            addr <= addr + 1'b1;
            acc_x <= acc_x ^ in_data;
            cnt <= cnt - 1'b1;
         end
      end
   end
endmodule
